// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and its display path:
// state encoding, count width, seconds rollover and the preset clamp.
package countdown_timer_pkg;

   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] SEC_MAX = 6'd59;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Saturates a preset to its limit before it ever reaches a register.
   function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] value,
                                              input logic [CNT_W-1:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/countdown_timer_edge.sv
// Rising-edge detector for a level signal already synchronous to clk.
// One registered delay stage; rise is high for exactly one cycle per edge.
module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic rise
);

   logic in_d;

   always_ff @(posedge clk) begin
      if (reset) in_d <= 1'b0;
      else       in_d <= in;
   end

   assign rise = in & ~in_d;

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer driven by the clock modulator's 1 Hz output.
// Load, start/pause control, registered count and run/done status.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter logic [CNT_W-1:0] MAX_MIN = 6'd59
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             load,
   input  logic [CNT_W-1:0] load_min,
   input  logic [CNT_W-1:0] load_sec,
   input  logic             start_pause,
   output logic [CNT_W-1:0] min_out,
   output logic [CNT_W-1:0] sec_out,
   output logic             running,
   output logic             done
);

   state_t           state;
   logic             tick_rise;
   logic [CNT_W-1:0] dec_min;
   logic [CNT_W-1:0] dec_sec;
   logic             dec_zero;
   logic             count_zero;

   rising_edge_detect u_tick_edge (
      .clk   (clk),
      .reset (reset),
      .in    (tick_in),
      .rise  (tick_rise)
   );

   assign count_zero = (min_out == '0) && (sec_out == '0);

   // Next count after one second; saturates at 00:00 so nothing wraps through 63.
   always_comb begin
      dec_min = min_out;
      dec_sec = sec_out;
      if (sec_out != '0) begin
         dec_sec = sec_out - 1'b1;
      end else if (min_out != '0) begin
         dec_min = min_out - 1'b1;
         dec_sec = SEC_MAX;
      end
      dec_zero = (dec_min == '0) && (dec_sec == '0);
   end

   // NOTE: state, count and status flags share one always_ff with <= so every
   // output is registered and updates together on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         min_out <= '0;
         sec_out <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (tick_rise) begin
                  min_out <= dec_min;
                  sec_out <= dec_sec;
               end
               // Reaching zero outranks a simultaneous pause request.
               if (tick_rise && dec_zero) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (start_pause) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            end
            default: begin
               if (load) begin
                  min_out <= clamp(load_min, MAX_MIN);
                  sec_out <= clamp(load_sec, SEC_MAX);
                  state   <= IDLE;
                  running <= 1'b0;
                  done    <= 1'b0;
               end else if (start_pause && (state == PAUSE ||
                                            (state == IDLE && !count_zero))) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b0;
   logic       load = 1'b0;
   logic [5:0] load_min = '0;
   logic [5:0] load_sec = '0;
   logic       start_pause = 1'b0;
   logic [5:0] min_out;
   logic [5:0] sec_out;
   logic       running;
   logic       done;

   typedef struct {
      string      name;
      logic [5:0] m;
      logic [5:0] s;
      logic       r;
      logic       d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   countdown_timer dut (
      .clk         (clk),
      .reset       (reset),
      .tick_in     (tick_in),
      .load        (load),
      .load_min    (load_min),
      .load_sec    (load_sec),
      .start_pause (start_pause),
      .min_out     (min_out),
      .sec_out     (sec_out),
      .running     (running),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d:%0d run=%0b done=%0b, expected %0d:%0d run=%0b done=%0b",
                  name, got[13:8], got[7:2], got[1], got[0],
                  want[13:8], want[7:2], want[1], want[0]);
      end
   endtask

   // Monitor: compares the registered outputs mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.name, {min_out, sec_out, running, done}, {e.m, e.s, e.r, e.d});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic ld, input logic sp, input logic tk,
                      input logic [5:0] m, input logic [5:0] s);
      load = ld; start_pause = sp; tick_in = tk; load_min = m; load_sec = s;
      step();
      load = 1'b0; start_pause = 1'b0;
   endtask

   task automatic do_load(input logic [5:0] m, input logic [5:0] s);
      cyc(1'b1, 1'b0, 1'b0, m, s);
   endtask

   task automatic do_sp();
      cyc(1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic do_tick();
      cyc(1'b0, 1'b0, 1'b1, '0, '0);
      tick_in = 1'b0;
      step();
   endtask

   task automatic expect_out(input string name, input logic [5:0] m, input logic [5:0] s,
                             input logic r, input logic d);
      exp_t e;
      e.name = name; e.m = m; e.s = s; e.r = r; e.d = d;
      exp_q.push_back(e);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) step();
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: monitor did not consume expectation, expected drained queue", name);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with the time base toggling underneath it.
      reset = 1'b1; tick_in = 1'b1; step();
      tick_in = 1'b0; step();
      reset = 1'b0;
      expect_out("reset", 0, 0, 0, 0);
      do_tick(); do_tick();
      expect_out("idle_ticks_after_reset", 0, 0, 0, 0);

      // Load and run.
      do_load(1, 5);
      expect_out("load_1_05", 1, 5, 0, 0);
      do_sp();
      expect_out("start_1_05", 1, 5, 1, 0);
      do_tick(); do_tick(); do_tick();
      expect_out("three_ticks", 1, 2, 1, 0);
      tick_in = 1'b1;
      repeat (10) step();
      tick_in = 1'b0; step();
      expect_out("held_high_one_decrement", 1, 1, 1, 0);
      do_load(5, 5);
      expect_out("load_in_run_ignored", 1, 1, 1, 0);

      // Minute borrow.
      do_sp();
      expect_out("pause_before_borrow", 1, 1, 0, 0);
      do_load(2, 0); do_sp(); do_tick();
      expect_out("minute_borrow", 1, 59, 1, 0);

      // Reach zero, stay done, reload.
      do_sp(); do_load(0, 2); do_sp(); do_tick(); do_tick();
      expect_out("reach_zero", 0, 0, 0, 1);
      do_tick(); do_sp(); do_tick();
      expect_out("done_holds", 0, 0, 0, 1);
      do_load(0, 10);
      expect_out("reload_clears_done", 0, 10, 0, 0);
      do_sp();
      expect_out("idle_to_run_after_reload", 0, 10, 1, 0);
      do_sp();

      // Pause behaviour and load/start_pause conflict.
      do_load(0, 30); do_sp(); do_tick();
      expect_out("run_0_29", 0, 29, 1, 0);
      do_sp();
      repeat (5) do_tick();
      expect_out("paused_ticks_frozen", 0, 29, 0, 0);
      do_sp(); do_tick();
      expect_out("resume_0_28", 0, 28, 1, 0);
      do_sp();
      cyc(1'b1, 1'b1, 1'b0, 0, 45);
      expect_out("load_wins_over_sp", 0, 45, 0, 0);
      do_tick();
      expect_out("idle_after_conflict_frozen", 0, 45, 0, 0);

      // Clamp and edge cases.
      do_load(63, 60);
      expect_out("clamp_59_59", 59, 59, 0, 0);
      do_load(0, 0); do_sp(); do_tick();
      expect_out("sp_at_zero_stays_idle", 0, 0, 0, 0);
      do_load(0, 1); do_sp();
      cyc(1'b0, 1'b1, 1'b1, 0, 0);
      tick_in = 1'b0; step();
      expect_out("tick_sp_zero_done_wins", 0, 0, 0, 1);
      do_load(0, 5); do_sp();
      cyc(1'b0, 1'b1, 1'b1, 0, 0);
      tick_in = 1'b0; step();
      expect_out("tick_sp_pauses", 0, 4, 0, 0);
      do_tick();
      expect_out("paused_after_tick_sp", 0, 4, 0, 0);

      // Reset mid-run.
      do_sp(); do_tick();
      expect_out("run_before_reset", 0, 3, 1, 0);
      reset = 1'b1; tick_in = 1'b1; step();
      reset = 1'b0;
      expect_out("reset_mid_run", 0, 0, 0, 0);
      tick_in = 1'b0; step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
